// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: responder FSM state encoding, default bus widths
// and the byte-lane count helper.
package wb_pkg;

  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_SEL_WIDTH  = (WB_DATA_WIDTH + 7) / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_state_e;

  function automatic int wb_sel_width(input int data_width);
    return (data_width + 7) / 8;
  endfunction

endpackage

// File: rtl/wb_slave_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered,
// read-enabled output that holds its value between reads.
module wb_slave_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  localparam int AW        = $clog2(DEPTH),
  localparam int BW        = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [BW-1:0]         i_be,
  input  logic                  i_re,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < BW; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone classic responder over a byte-lane-writable word memory with WAIT_STATES extra cycles.
// Define WB_SLAVE_ERR_EN to terminate out-of-range accesses with wb_err_o instead of aliasing.
module wb_slave_mem
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH  = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = WB_DATA_WIDTH,
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                                wb_clk,
  input  logic                                wb_rst_n,
  input  logic                                wb_cyc_i,
  input  logic                                wb_stb_i,
  input  logic                                wb_we_i,
  input  logic [ADDR_WIDTH-1:0]               wb_adr_i,
  input  logic [wb_sel_width(DATA_WIDTH)-1:0] wb_sel_i,
  input  logic [DATA_WIDTH-1:0]               wb_dat_i,
  output logic [DATA_WIDTH-1:0]               wb_dat_o,
  output logic                                wb_ack_o,
  output logic                                wb_err_o
);

  localparam int SEL_W = wb_sel_width(DATA_WIDTH);
  localparam int IDX_W = $clog2(MEM_WORDS);

  wb_state_e             r_state, w_state_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic                  r_we, r_oor, r_rd_valid;
  logic [IDX_W-1:0]      r_idx;
  logic [SEL_W-1:0]      r_sel;
  logic [DATA_WIDTH-1:0] r_dat;

  logic                  w_accept, w_to_ack, w_bus_oor;
  logic                  w_req_we, w_req_oor, w_ram_we, w_ram_re;
  logic [IDX_W-1:0]      w_req_idx;
  logic [SEL_W-1:0]      w_req_sel;
  logic [DATA_WIDTH-1:0] w_req_dat, w_ram_rdata;

`ifdef WB_SLAVE_ERR_EN
  assign w_bus_oor = |(wb_adr_i >> IDX_W);
`else
  logic w_unused_adr;
  assign w_unused_adr = ^wb_adr_i;
  assign w_bus_oor    = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_to_ack     = 1'b0;
    case (r_state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          w_accept   = 1'b1;
          w_cnt_next = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            w_state_next = ACK;
            w_to_ack     = 1'b1;
          end else begin
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_state_next = ACK;
            w_to_ack     = 1'b1;
          end
        end
      end
      ACK:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // With zero wait states the memory access happens in the accepting cycle, so take the live bus.
  assign w_req_we  = (r_state == IDLE) ? wb_we_i                : r_we;
  assign w_req_oor = (r_state == IDLE) ? w_bus_oor              : r_oor;
  assign w_req_idx = (r_state == IDLE) ? wb_adr_i[IDX_W-1:0]    : r_idx;
  assign w_req_sel = (r_state == IDLE) ? wb_sel_i               : r_sel;
  assign w_req_dat = (r_state == IDLE) ? wb_dat_i               : r_dat;

  assign w_ram_we = wb_rst_n && w_to_ack &&  w_req_we && !w_req_oor;
  assign w_ram_re = wb_rst_n && w_to_ack && !w_req_we && !w_req_oor;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_oor      <= 1'b0;
      r_idx      <= '0;
      r_sel      <= '0;
      r_dat      <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_we  <= wb_we_i;
        r_oor <= w_bus_oor;
        r_idx <= wb_adr_i[IDX_W-1:0];
        r_sel <= wb_sel_i;
        r_dat <= wb_dat_i;
      end
      if (w_ram_re) r_rd_valid <= 1'b1;
    end
  end

  wb_slave_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_WORDS)
  ) u_ram (
    .i_clk   (wb_clk),
    .i_we    (w_ram_we),
    .i_be    (w_req_sel),
    .i_re    (w_ram_re),
    .i_addr  (w_req_idx),
    .i_wdata (w_req_dat),
    .o_rdata (w_ram_rdata)
  );

  // The RAM output register has no reset; r_rd_valid masks it to zero until the first read.
  assign wb_dat_o = r_rd_valid ? w_ram_rdata : '0;
  assign wb_ack_o = (r_state == ACK) && !r_oor;
`ifdef WB_SLAVE_ERR_EN
  assign wb_err_o = (r_state == ACK) && r_oor;
`else
  assign wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_slave_mem.sv
// Scoreboard bench for wb_slave_mem: three responders (0, 3 and 5 wait states) on one clock.
`timescale 1ns/1ps
module tb_wb_slave_mem;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cyc [NDUT];
  logic        stb [NDUT];
  logic        we  [NDUT];
  logic        ack [NDUT];
  logic        err [NDUT];
  logic [31:0] adr [NDUT];
  logic [3:0]  sel [NDUT];
  logic [31:0] dwr [NDUT];
  logic [31:0] drd [NDUT];

  function automatic int ws_of(input int k);
    case (k)
      0:       return 0;
      1:       return 3;
      default: return 5;
    endcase
  endfunction

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    wb_slave_mem #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .MEM_WORDS   (256),
      .WAIT_STATES (ws_of(gi))
    ) u_dut (
      .wb_clk   (clk),
      .wb_rst_n (rst_n),
      .wb_cyc_i (cyc[gi]),
      .wb_stb_i (stb[gi]),
      .wb_we_i  (we[gi]),
      .wb_adr_i (adr[gi]),
      .wb_sel_i (sel[gi]),
      .wb_dat_i (dwr[gi]),
      .wb_dat_o (drd[gi]),
      .wb_ack_o (ack[gi]),
      .wb_err_o (err[gi])
    );
  end

  typedef struct {
    int          k;
    bit          is_err;
    bit          chk;
    logic [31:0] dat;
    int unsigned at;
  } exp_t;

  exp_t        q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned cyc_cnt     = 0;
  int          n_term [NDUT] = '{0, 0, 0};
  bit          prev_term [NDUT] = '{0, 0, 0};

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %08h, required %08h", name, got, want);
    end
  endtask

  // Monitor: every termination pops the oldest expectation and is compared against it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        if (ack[k] || err[k]) begin
          n_term[k]++;
          vectors++;
          if (prev_term[k]) begin
            miscompares++;
            $display("FAIL ack_width dut%0d: termination high two cycles at cycle %0d, required one", k, cyc_cnt);
          end
          vectors++;
          if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_term dut%0d at cycle %0d: ack=%0b err=%0b, required none", k, cyc_cnt, ack[k], err[k]);
          end else begin
            e = q.pop_front();
            if (e.k != k || err[k] !== e.is_err || ack[k] !== !e.is_err || e.at != cyc_cnt ||
                (e.chk && drd[k] !== e.dat)) begin
              miscompares++;
              $display("FAIL term dut%0d: got ack=%0b err=%0b cycle=%0d dat=%08h, required dut%0d err=%0b cycle=%0d dat=%08h",
                       k, ack[k], err[k], cyc_cnt, drd[k], e.k, e.is_err, e.at, e.dat);
            end else begin
              $display("term dut%0d err=%0b cycle=%0d dat=%08h", k, err[k], cyc_cnt, drd[k]);
            end
          end
        end
        prev_term[k] = ack[k] || err[k];
      end
    end
  end

  task automatic xfer(input int k, input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input bit exp_err, input bit chk,
                      input logic [31:0] exp_d, input bit hold, input bit scr);
    exp_t e;
    bit   done;
    int   n0;
    @(posedge clk); #1;
    e.k = k; e.is_err = exp_err; e.chk = chk; e.dat = exp_d;
    e.at = cyc_cnt + 1 + ws_of(k);
    q.push_back(e);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; dwr[k] = d;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (ack[k] || err[k]) done = 1'b1;
      else if (scr && i == 1) begin
        adr[k] = adr[k] ^ 32'h1; dwr[k] = ~dwr[k]; sel[k] = 4'h0;
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL timeout dut%0d adr=%08h: no termination within 40 cycles, required one", k, a);
      if (q.size() > 0) q.delete(q.size() - 1);
    end
    @(posedge clk); #1;
    n0 = n_term[k];
    if (hold) begin
      @(posedge clk); #1;
    end
    cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
    if (hold) begin
      repeat (10) @(posedge clk);
      #1;
      check($sformatf("no_second_ack dut%0d", k), 32'(n_term[k]), 32'(n0));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int n0;
    rst_n = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      cyc[k] = 0; stb[k] = 0; we[k] = 0; adr[k] = 0; sel[k] = 0; dwr[k] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("reset_ack dut%0d", k), 32'(ack[k]), 32'h0);
      check($sformatf("reset_err dut%0d", k), 32'(err[k]), 32'h0);
      check($sformatf("reset_dat dut%0d", k), drd[k], 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Zero wait states: full word, byte lanes, sel=0 write, read independent of sel.
    xfer(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0);
    xfer(0, 0, 32'h10, 4'hF, 32'h0,        0, 1, 32'hDEADBEEF, 0, 0);
    xfer(0, 1, 32'h20, 4'hF, 32'h11223344, 0, 0, 32'h0,        0, 0);
    xfer(0, 1, 32'h20, 4'h8, 32'hAA000000, 0, 0, 32'h0,        0, 0);
    xfer(0, 1, 32'h20, 4'h1, 32'h000000BB, 0, 0, 32'h0,        0, 0);
    xfer(0, 0, 32'h20, 4'hF, 32'h0,        0, 1, 32'hAA2233BB, 0, 0);
    xfer(0, 0, 32'h20, 4'h0, 32'h0,        0, 1, 32'hAA2233BB, 0, 0);
    xfer(0, 1, 32'h21, 4'hF, 32'hCAFEF00D, 0, 0, 32'h0,        0, 0);
    xfer(0, 1, 32'h21, 4'h0, 32'hFFFFFFFF, 0, 0, 32'h0,        0, 0);
    xfer(0, 0, 32'h21, 4'hF, 32'h0,        0, 1, 32'hCAFEF00D, 0, 0);
    xfer(0, 1, 32'h00, 4'hF, 32'h12345678, 0, 0, 32'h0,        0, 0);

    // Out-of-range address 0x100 on a 256-word memory.
`ifdef WB_SLAVE_ERR_EN
    xfer(0, 1, 32'h100, 4'hF, 32'h0BADF00D, 1, 0, 32'h0,        0, 0);
    xfer(0, 0, 32'h000, 4'hF, 32'h0,        0, 1, 32'h12345678, 0, 0);
    xfer(0, 0, 32'h100, 4'hF, 32'h0,        1, 1, 32'h12345678, 0, 0);
`else
    xfer(0, 1, 32'h100, 4'hF, 32'h0BADF00D, 0, 0, 32'h0,        0, 0);
    xfer(0, 0, 32'h000, 4'hF, 32'h0,        0, 1, 32'h0BADF00D, 0, 0);
    xfer(0, 0, 32'h100, 4'hF, 32'h0,        0, 1, 32'h0BADF00D, 0, 0);
    xfer(0, 1, 32'h1FF, 4'hF, 32'h0F0F0F0F, 0, 0, 32'h0,        0, 0);
    xfer(0, 0, 32'h0FF, 4'hF, 32'h0,        0, 1, 32'h0F0F0F0F, 0, 0);
`endif

    // Three wait states: latency, single-cycle ack, stb held one cycle into IDLE.
    xfer(1, 1, 32'h5, 4'hF, 32'hA5A55A5A, 0, 0, 32'h0,        0, 0);
    xfer(1, 0, 32'h5, 4'hF, 32'h0,        0, 1, 32'hA5A55A5A, 1, 0);

    // Reset while the read sits in WAIT.
    @(posedge clk); #1;
    cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 32'h5; sel[1] = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check("dat_held_before_reset", drd[1], 32'hA5A55A5A);
    rst_n = 1'b0;
    #1;
    check("reset_async_ack", 32'(ack[1]), 32'h0);
    check("reset_async_dat", drd[1], 32'h0);
    $display("reset asserted mid-transfer at cycle %0d", cyc_cnt);
    cyc[1] = 0; stb[1] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(1, 0, 32'h5, 4'hF, 32'h0, 0, 1, 32'hA5A55A5A, 0, 0);

    // Five wait states: abort after two cycles drops the write.
    xfer(2, 1, 32'h2, 4'hF, 32'h0, 0, 0, 32'h0, 0, 0);
    @(posedge clk); #1;
    n0 = n_term[2];
    cyc[2] = 1; stb[2] = 1; we[2] = 1; adr[2] = 32'h2; sel[2] = 4'hF; dwr[2] = 32'h55;
    repeat (2) @(posedge clk);
    #1;
    cyc[2] = 0; stb[2] = 0; we[2] = 0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_ack", 32'(n_term[2]), 32'(n0));
    $display("abort issued on dut2 adr=00000002");
    xfer(2, 0, 32'h2, 4'hF, 32'h0, 0, 1, 32'h0, 0, 0);

    // Bus changes after acceptance must be ignored.
    xfer(2, 1, 32'h3, 4'hF, 32'h13572468, 0, 0, 32'h0,        0, 1);
    xfer(2, 0, 32'h3, 4'hF, 32'h0,        0, 1, 32'h13572468, 0, 0);
    xfer(2, 0, 32'h2, 4'hF, 32'h0,        0, 1, 32'h0,        0, 0);
    xfer(2, 0, 32'h3, 4'hF, 32'h0,        0, 1, 32'h13572468, 0, 1);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
